// File: rtl/relay_rr_arbiter_if.sv
// relay_rr_arbiter_if
// Bundles the upstream FWFT read side and the downstream write side of the
// round-robin relay arbiter.
//
// Handshakes:
//   Upstream port i (FWFT): in_empty_n[i]=1 means in_dout slice i holds a valid
//   word. A word is consumed in every cycle where in_read[i]=1. in_read[i] is
//   only raised while in_empty_n[i]=1, and never for more than one port.
//   Downstream: a word is accepted in every cycle where out_write=1. out_full_n
//   is an almost-full flag, so one write in the cycle after it falls is
//   absorbed by the downstream slack.
//
// Signals:
//   in_empty_n [NUM_PORTS]             per-port data valid
//   in_read    [NUM_PORTS]             per-port read strobe (combinational)
//   in_dout    [NUM_PORTS*DATA_WIDTH]  port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   out_full_n                         downstream not-almost-full
//   out_write, out_din, out_sel        registered write strobe, data, source port
//   locked                             registered; 1 while a packet holds the grant
//   dbg_state                          FSM state (0 = IDLE, 1 = LOCKED)
interface relay_rr_arbiter_if #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
);
  logic [NUM_PORTS-1:0]            in_empty_n;
  logic [NUM_PORTS-1:0]            in_read;
  logic [NUM_PORTS*DATA_WIDTH-1:0] in_dout;
  logic                            out_full_n;
  logic                            out_write;
  logic [DATA_WIDTH-1:0]           out_din;
  logic [SEL_WIDTH-1:0]            out_sel;
  logic                            locked;
  logic                            dbg_state;

  // Arbiter side.
  modport master (
    input  in_empty_n, in_dout, out_full_n,
    output in_read, out_write, out_din, out_sel, locked, dbg_state
  );

  // Environment side: upstream FIFOs and downstream relay station.
  modport slave (
    output in_empty_n, in_dout, out_full_n,
    input  in_read, out_write, out_din, out_sel, locked, dbg_state
  );
endinterface

// File: rtl/relay_rr_arbiter.sv
// relay_rr_arbiter
// N:1 round-robin arbiter that merges NUM_PORTS FWFT streams into the write
// side of one downstream relay station. With LOCK_ON_LAST=1 a multi-word
// packet (bit DATA_WIDTH-1 = last flag) keeps the grant until its last word
// has been transferred. Output is registered: one pipeline stage.
//
// Ports:
//   clk    clock
//   reset  synchronous, active-high reset
//   bus    relay_rr_arbiter_if.master (in_empty_n/in_read/in_dout,
//          out_full_n/out_write/out_din/out_sel, locked, dbg_state)
module relay_rr_arbiter #(
  parameter int NUM_PORTS    = 4,
  parameter int DATA_WIDTH   = 32,
  parameter bit LOCK_ON_LAST = 1'b1,
  parameter int SEL_WIDTH    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input logic                clk,
  input logic                reset,
  relay_rr_arbiter_if.master bus
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t                state;
  logic [SEL_WIDTH-1:0]  ptr;        // last granted port; scan starts after it
  logic [SEL_WIDTH-1:0]  lock_port;
  logic [SEL_WIDTH-1:0]  grant;
  logic [SEL_WIDTH-1:0]  scan_idx;
  logic                  grant_valid;
  logic                  xfer;
  logic                  last_flag;
  logic [DATA_WIDTH-1:0] grant_data;
  logic [NUM_PORTS-1:0]  read_vec;

  logic                  out_write_q;
  logic [DATA_WIDTH-1:0] out_din_q;
  logic [SEL_WIDTH-1:0]  out_sel_q;
  logic                  locked_q;

  // Grant selection. In IDLE the scan visits ptr+1 .. ptr (wrapping) and the
  // first valid port wins, so the port served last has the lowest priority.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    scan_idx    = '0;
    if (state == LOCKED) begin
      grant       = lock_port;
      grant_valid = bus.in_empty_n[lock_port];
    end else begin
      for (int k = 1; k <= NUM_PORTS; k++) begin
        scan_idx = SEL_WIDTH'((int'(ptr) + k) % NUM_PORTS);
        if (!grant_valid && bus.in_empty_n[scan_idx]) begin
          grant       = scan_idx;
          grant_valid = 1'b1;
        end
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant == SEL_WIDTH'(i)) begin
        grant_data = bus.in_dout[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign last_flag = grant_data[DATA_WIDTH-1];

  // out_full_n is used combinationally: the single write that can follow its
  // falling edge lands in the downstream grace slack.
  assign xfer = !reset && bus.out_full_n && grant_valid;

  always_comb begin
    read_vec = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (xfer && (grant == SEL_WIDTH'(i))) begin
        read_vec[i] = 1'b1;
      end
    end
  end

  assign bus.in_read = read_vec;

  // State, pointer and lock only move on a transfer, so they freeze while
  // out_full_n=0 or while the locked port bubbles.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= SEL_WIDTH'(NUM_PORTS - 1);
      lock_port   <= '0;
      out_write_q <= 1'b0;
      out_din_q   <= '0;
      out_sel_q   <= '0;
      locked_q    <= 1'b0;
    end else begin
      out_write_q <= xfer;
      if (xfer) begin
        out_din_q <= grant_data;
        out_sel_q <= grant;
        ptr       <= grant;
        if (LOCK_ON_LAST) begin
          case (state)
            IDLE: begin
              if (!last_flag) begin
                state     <= LOCKED;
                lock_port <= grant;
                locked_q  <= 1'b1;
              end
            end
            LOCKED: begin
              if (last_flag) begin
                state    <= IDLE;
                locked_q <= 1'b0;
              end
            end
            default: begin
              state    <= IDLE;
              locked_q <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign bus.out_write = out_write_q;
  assign bus.out_din   = out_din_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.locked    = locked_q;
  assign bus.dbg_state = (state == LOCKED);

endmodule

// File: tb/tb_relay_rr_arbiter.sv
// tb_relay_rr_arbiter
// Two arbiters share clock, reset and out_full_n: dut_a with LOCK_ON_LAST=1,
// dut_b with LOCK_ON_LAST=0. Each has its own upstream FIFO model (queues).
// A behavioural model (last-served port + optional locked port, modulo scan)
// predicts in_read every cycle and the registered outputs one cycle later;
// written words go through an expected queue scoreboard.
module tb_relay_rr_arbiter;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int SW = 2;

  logic clk;
  logic rst;
  logic full_n;

  relay_rr_arbiter_if #(.NUM_PORTS(N), .DATA_WIDTH(W), .SEL_WIDTH(SW)) bus_a ();
  relay_rr_arbiter_if #(.NUM_PORTS(N), .DATA_WIDTH(W), .SEL_WIDTH(SW)) bus_b ();

  relay_rr_arbiter #(.NUM_PORTS(N), .DATA_WIDTH(W), .LOCK_ON_LAST(1'b1)) dut_a (
    .clk   (clk),
    .reset (rst),
    .bus   (bus_a.master)
  );

  relay_rr_arbiter #(.NUM_PORTS(N), .DATA_WIDTH(W), .LOCK_ON_LAST(1'b0)) dut_b (
    .clk   (clk),
    .reset (rst),
    .bus   (bus_b.master)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  logic [W-1:0] src_q [2][N][$];
  logic [N-1:0] src_en [2];
  int           seq_n [2][N];
  bit           lock_cfg [2];

  int           m_last [2];
  int           m_lock [2];
  int           g_exp [2];
  logic         e_write [2];
  logic [W-1:0] e_din [2];
  logic [SW-1:0] e_sel [2];
  logic         e_locked [2];
  logic [W-1:0] exp_q [2][$];

  logic [N-1:0] cap_rd [2];
  logic [N-1:0] cap_en [2];
  logic         cap_ow [2];
  logic [W-1:0] cap_din [2];
  logic [SW-1:0] cap_sel [2];
  logic         cap_lk [2];

  bit soak_on;
  int rd_open;
  int out_open;
  int wait_cnt [N];
  int starve_max;
  int contig_viol;

  typedef struct {
    logic [N-1:0] en;
    logic         full;
    logic [N-1:0] rd;
    logic [SW-1:0] sel;
    logic [W-1:0] din;
  } vec_t;
  vec_t vecs [16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit port_valid(int d, int p);
    return src_en[d][p] && (src_q[d][p].size() > 0);
  endfunction

  function automatic int exp_grant(int d);
    if (m_lock[d] >= 0) return port_valid(d, m_lock[d]) ? m_lock[d] : -1;
    for (int k = 1; k <= N; k++) begin
      int p;
      p = (m_last[d] + k) % N;
      if (port_valid(d, p)) return p;
    end
    return -1;
  endfunction

  task automatic model_reset(input int d);
    m_last[d]   = N - 1;
    m_lock[d]   = -1;
    e_write[d]  = 1'b0;
    e_din[d]    = '0;
    e_sel[d]    = '0;
    e_locked[d] = 1'b0;
    exp_q[d].delete();
  endtask

  task automatic model_check(input int d);
    logic [W-1:0] exp_w;
    logic [N-1:0] exp_rd;
    chk($sformatf("out_write_%0d", d), cap_ow[d], e_write[d]);
    if (cap_ow[d]) begin
      exp_w = (exp_q[d].size() > 0) ? exp_q[d].pop_front() : 'x;
      chk($sformatf("sb_din_%0d", d), cap_din[d], exp_w);
    end else begin
      chk($sformatf("din_hold_%0d", d), cap_din[d], e_din[d]);
    end
    chk($sformatf("out_sel_%0d", d), cap_sel[d], e_sel[d]);
    chk($sformatf("locked_%0d", d), cap_lk[d], e_locked[d]);
    g_exp[d] = (rst || !full_n) ? -1 : exp_grant(d);
    exp_rd = (g_exp[d] < 0) ? '0 : N'(1 << g_exp[d]);
    chk($sformatf("in_read_%0d", d), cap_rd[d], exp_rd);
  endtask

  task automatic model_step(input int d);
    logic [W-1:0] w;
    int g;
    g = g_exp[d];
    if (rst) begin
      model_reset(d);
    end else if (g >= 0) begin
      w = src_q[d][g].pop_front();
      exp_q[d].push_back(w);
      e_write[d] = 1'b1;
      e_din[d]   = w;
      e_sel[d]   = SW'(g);
      m_last[d]  = g;
      if (lock_cfg[d]) begin
        if (m_lock[d] < 0 && !w[W-1]) m_lock[d] = g;
        else if (m_lock[d] >= 0 && w[W-1]) m_lock[d] = -1;
      end
      e_locked[d] = (m_lock[d] >= 0);
    end else begin
      e_write[d] = 1'b0;
    end
  endtask

  // ---------------- driver ----------------
  task automatic refresh();
    logic [N*W-1:0] dv;
    logic [N-1:0]   ev;
    for (int d = 0; d < 2; d++) begin
      dv = '0;
      ev = '0;
      for (int p = 0; p < N; p++) begin
        if (src_q[d][p].size() > 0) begin
          ev[p] = src_en[d][p];
          dv[p*W +: W] = src_q[d][p][0];
        end
      end
      if (d == 0) begin
        bus_a.in_empty_n = ev;
        bus_a.in_dout    = dv;
        bus_a.out_full_n = full_n;
      end else begin
        bus_b.in_empty_n = ev;
        bus_b.in_dout    = dv;
        bus_b.out_full_n = full_n;
      end
    end
  endtask

  task automatic push_packet(input int d, input int p);
    int len;
    len = $urandom_range(1, 8);
    for (int i = 0; i < len; i++) begin
      src_q[d][p].push_back({(i == len - 1), 3'b000, 4'(p), 24'(seq_n[d][p])});
      seq_n[d][p]++;
    end
  endtask

  // Fairness and packet contiguity observed on dut_a during the soak.
  task automatic soak_track();
    int q;
    bit start;
    logic [W-1:0] w;
    if (cap_ow[0]) begin
      if (out_open >= 0 && int'(cap_sel[0]) != out_open) contig_viol++;
      out_open = cap_din[0][W-1] ? -1 : int'(cap_sel[0]);
    end
    q = -1;
    for (int p = 0; p < N; p++) if (cap_rd[0][p]) q = p;
    if (q >= 0) begin
      start = (rd_open < 0);
      w = bus_a.in_dout[q*W +: W];
      for (int p = 0; p < N; p++) begin
        if (p != q && cap_en[0][p] && start) wait_cnt[p]++;
        if (wait_cnt[p] > starve_max) starve_max = wait_cnt[p];
      end
      if (start && !w[W-1]) rd_open = q;
      else if (!start && w[W-1]) rd_open = -1;
    end
    for (int p = 0; p < N; p++) begin
      if (cap_rd[0][p] || !cap_en[0][p]) wait_cnt[p] = 0;
    end
  endtask

  // One cycle: sample and check at negedge, advance model and drive after posedge.
  task automatic tick();
    @(negedge clk);
    cap_rd[0] = bus_a.in_read;  cap_en[0] = bus_a.in_empty_n; cap_ow[0] = bus_a.out_write;
    cap_din[0] = bus_a.out_din; cap_sel[0] = bus_a.out_sel;   cap_lk[0] = bus_a.locked;
    cap_rd[1] = bus_b.in_read;  cap_en[1] = bus_b.in_empty_n; cap_ow[1] = bus_b.out_write;
    cap_din[1] = bus_b.out_din; cap_sel[1] = bus_b.out_sel;   cap_lk[1] = bus_b.locked;
    for (int d = 0; d < 2; d++) model_check(d);
    if (soak_on) soak_track();
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) model_step(d);
    refresh();
  endtask

  task automatic do_reset();
    for (int d = 0; d < 2; d++) begin
      src_en[d] = '0;
      for (int p = 0; p < N; p++) src_q[d][p].delete();
    end
    full_n = 1'b1;
    rst = 1'b1;
    refresh();
    tick();
    rst = 1'b0;
    refresh();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int writes;
    lock_cfg[0] = 1'b1;
    lock_cfg[1] = 1'b0;
    soak_on = 1'b0;
    full_n = 1'b1;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      model_reset(d);
      src_en[d] = '1;
      for (int p = 0; p < N; p++) seq_n[d][p] = 0;
    end
    for (int p = 0; p < N; p++) begin
      for (int k = 0; k < 16; k++) begin
        src_q[1][p].push_back(W'(32'h100 * p + k));
        src_q[0][p].push_back(W'(32'h8000_0000 + 32'h100 * p + k));
      end
    end
    refresh();
    @(posedge clk);
    #1;

    // Reset defaults: nothing read while reset is high.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_rd_a", cap_rd[0], 4'b0000);
      chk("rst_rd_b", cap_rd[1], 4'b0000);
    end
    rst = 1'b0;
    src_en[0] = '0;
    src_en[1] = '0;
    refresh();
    tick();
    chk("rst_out_write", cap_ow[0], 1'b0);
    chk("rst_out_sel", cap_sel[0], 2'd0);
    chk("rst_locked", cap_lk[0], 1'b0);
    for (int p = 0; p < N; p++) src_q[0][p].delete();

    // Table-driven vectors on dut_b (no packet lock); data = 0x100*port + k.
    vecs[0]  = '{4'b1111, 1'b1, 4'b0001, 2'd0, 32'h000};
    vecs[1]  = '{4'b1111, 1'b1, 4'b0010, 2'd1, 32'h100};
    vecs[2]  = '{4'b1111, 1'b1, 4'b0100, 2'd2, 32'h200};
    vecs[3]  = '{4'b1111, 1'b1, 4'b1000, 2'd3, 32'h300};
    vecs[4]  = '{4'b1111, 1'b1, 4'b0001, 2'd0, 32'h001};
    vecs[5]  = '{4'b1111, 1'b1, 4'b0010, 2'd1, 32'h101};
    vecs[6]  = '{4'b1111, 1'b1, 4'b0100, 2'd2, 32'h201};
    vecs[7]  = '{4'b1111, 1'b1, 4'b1000, 2'd3, 32'h301};
    vecs[8]  = '{4'b1001, 1'b1, 4'b0001, 2'd0, 32'h002};
    vecs[9]  = '{4'b0001, 1'b1, 4'b0001, 2'd0, 32'h003};
    vecs[10] = '{4'b1111, 1'b0, 4'b0000, 2'd0, 32'h000};
    vecs[11] = '{4'b1111, 1'b1, 4'b0010, 2'd1, 32'h102};
    vecs[12] = '{4'b0100, 1'b1, 4'b0100, 2'd2, 32'h202};
    vecs[13] = '{4'b0000, 1'b1, 4'b0000, 2'd0, 32'h000};
    vecs[14] = '{4'b1011, 1'b1, 4'b1000, 2'd3, 32'h302};
    vecs[15] = '{4'b0110, 1'b1, 4'b0010, 2'd1, 32'h103};
    for (int i = 0; i < 16; i++) begin
      src_en[1] = vecs[i].en;
      full_n = vecs[i].full;
      refresh();
      tick();
      chk("tbl_rd", cap_rd[1], vecs[i].rd);
      if (i > 0) begin
        chk("tbl_wr", cap_ow[1], (vecs[i-1].rd != 0));
        if (vecs[i-1].rd != 0) begin
          chk("tbl_sel", cap_sel[1], vecs[i-1].sel);
          chk("tbl_din", cap_din[1], vecs[i-1].din);
        end
      end
    end
    src_en[1] = '0;
    full_n = 1'b1;
    refresh();
    tick();
    chk("tbl_last_wr", cap_ow[1], 1'b1);
    chk("tbl_last_sel", cap_sel[1], vecs[15].sel);
    chk("tbl_last_din", cap_din[1], vecs[15].din);

    // Packet lock: port 1 sends 3 words with a 2-cycle bubble, port 2 waits.
    do_reset();
    src_q[0][1].push_back(32'h0010_0001);
    src_q[0][1].push_back(32'h0010_0002);
    src_q[0][1].push_back(32'h8010_0003);
    for (int k = 0; k < 6; k++) src_q[0][2].push_back(W'(32'h8020_0000 + k));
    src_en[0] = 4'b0110;
    refresh();
    tick();
    chk("lk_first_rd", cap_rd[0], 4'b0010);
    src_en[0] = 4'b0100;
    refresh();
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("lk_bubble_rd", cap_rd[0], 4'b0000);
      chk("lk_bubble_locked", cap_lk[0], 1'b1);
    end
    src_en[0] = 4'b0110;
    refresh();
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("lk_body_rd", cap_rd[0], 4'b0010);
      chk("lk_body_locked", cap_lk[0], 1'b1);
    end
    tick();
    chk("lk_release_rd", cap_rd[0], 4'b0100);
    chk("lk_release_locked", cap_lk[0], 1'b0);
    chk("lk_last_sel", cap_sel[0], 2'd1);
    tick();
    chk("lk_next_wr", cap_ow[0], 1'b1);
    chk("lk_next_sel", cap_sel[0], 2'd2);

    // Backpressure: steady port 0 stream, out_full_n low for 5 cycles.
    do_reset();
    for (int k = 0; k < 20; k++) src_q[0][0].push_back(W'(32'h8000_0000 + k));
    src_en[0] = 4'b0001;
    refresh();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_steady_rd", cap_rd[0], 4'b0001);
    end
    full_n = 1'b0;
    refresh();
    writes = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_stall_rd", cap_rd[0], 4'b0000);
      if (i > 0) chk("bp_stall_wr", cap_ow[0], 1'b0);
      writes += int'(cap_ow[0]);
    end
    chk("bp_writes_after_fall", writes, 1);
    full_n = 1'b1;
    refresh();
    tick();
    chk("bp_resume_rd", cap_rd[0], 4'b0001);
    tick();
    chk("bp_resume_wr", cap_ow[0], 1'b1);

    // Reset while locked on port 3.
    do_reset();
    for (int k = 0; k < 4; k++) src_q[0][3].push_back({(k == 3), 31'(32'h0030_0000 + k)});
    for (int k = 0; k < 4; k++) src_q[0][0].push_back(W'(32'h8000_0100 + k));
    src_en[0] = 4'b1000;
    refresh();
    tick();
    chk("rm_rd1", cap_rd[0], 4'b1000);
    tick();
    chk("rm_rd2", cap_rd[0], 4'b1000);
    chk("rm_locked", cap_lk[0], 1'b1);
    rst = 1'b1;
    refresh();
    tick();
    chk("rm_reset_rd", cap_rd[0], 4'b0000);
    rst = 1'b0;
    src_en[0] = 4'b1001;
    refresh();
    tick();
    chk("rm_unlocked", cap_lk[0], 1'b0);
    chk("rm_no_write", cap_ow[0], 1'b0);
    chk("rm_port0_wins", cap_rd[0], 4'b0001);

    // Random soak.
    do_reset();
    rd_open = -1;
    out_open = -1;
    starve_max = 0;
    contig_viol = 0;
    for (int p = 0; p < N; p++) wait_cnt[p] = 0;
    soak_on = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      for (int d = 0; d < 2; d++) begin
        for (int p = 0; p < N; p++) begin
          if (src_q[d][p].size() < 4) push_packet(d, p);
          src_en[d][p] = ($urandom_range(0, 9) < 8);
        end
      end
      full_n = ($urandom_range(0, 3) != 0);
      refresh();
      tick();
    end
    soak_on = 1'b0;
    full_n = 1'b1;
    src_en[0] = '0;
    src_en[1] = '0;
    refresh();
    tick();
    tick();
    chk("soak_contiguous", contig_viol, 0);
    chk("soak_starve_bound", (starve_max <= N - 1), 1'b1);
    chk("soak_drain_a", exp_q[0].size(), 0);
    chk("soak_drain_b", exp_q[1].size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/relay_rr_arbiter.md
Name: relay_rr_arbiter

Overview:
N:1 round-robin arbiter merging NUM_PORTS first-word fall-through stream outputs into the write side of one downstream relay_station.
- Inputs are read with the FWFT empty_n/read handshake.
- Output is written with the write/full_n handshake. Downstream full_n is an almost-full flag with grace-period slack.
- Optional packet lock keeps multi-word bursts atomic: grant is held until a word with the last flag set is transferred.
- Output is registered, so the block adds exactly one pipeline stage.

Parameters:
NUM_PORTS, 4, number of input streams; legal range 1..16.
DATA_WIDTH, 32, word width; bit DATA_WIDTH-1 is the last flag when LOCK_ON_LAST=1.
LOCK_ON_LAST, 1, 1 = hold grant until a last-flagged word; 0 = re-arbitrate after every word.
SEL_WIDTH, derived, max(1, $clog2(NUM_PORTS)); not to be overridden.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
in_empty_n  input  NUM_PORTS  per-port data-valid (FWFT); bit i = port i
in_read  output  NUM_PORTS  per-port read strobe; at most one bit high; combinational
in_dout  input  NUM_PORTS*DATA_WIDTH  port i data at bits [i*DATA_WIDTH +: DATA_WIDTH]
out_full_n  input  1  downstream not-almost-full
out_write  output  1  registered write strobe to downstream
out_din  output  DATA_WIDTH  registered write data
out_sel  output  SEL_WIDTH  registered source-port index of the word on out_din
locked  output  1  registered; 1 while the FSM is in LOCKED

Behaviour:
- Reset values: out_write=0, out_din=0, out_sel=0, locked=0, state=IDLE, ptr=NUM_PORTS-1 (port 0 has first priority).
- in_read is forced to all zeros while reset=1.
- Transfer condition: in_read[g]=1 iff all of the following hold:
  - reset=0;
  - out_full_n=1;
  - in_empty_n[g]=1;
  - g is the grant for this cycle.
- Grant selection:
  - IDLE: g = first i with in_empty_n[i]=1, scanning ptr+1, ptr+2, ..., wrapping NUM_PORTS-1 -> 0, ending at ptr.
  - LOCKED: g = lock_port; no other port is ever granted.
- Next cycle after a transfer from port g: out_write=1, out_din=in_dout[g], out_sel=g, ptr=g.
- Cycle with no transfer: out_write=0; out_din and out_sel hold their values.
- Latency: input word to out_write/out_din is exactly 1 cycle. Throughput is 1 word/cycle while out_full_n=1.
- FSM (LOCK_ON_LAST=1), states IDLE and LOCKED:
  - IDLE -> LOCKED: transfer with last flag=0; lock_port=g.
  - IDLE -> IDLE: no transfer, or transfer with last flag=1 (single-word packet).
  - LOCKED -> IDLE: transfer from lock_port with last flag=1.
  - LOCKED -> LOCKED: anything else, including lock_port empty (bubble). Other ports wait even if valid.
- LOCK_ON_LAST=0: FSM stays in IDLE; the last flag is ignored and passed through as data; locked stays 0.
- Backpressure: out_full_n is used combinationally with no extra registering. The block issues at most one write in the cycle after out_full_n falls, which is covered by the downstream grace period. While out_full_n=0: all in_read=0; state, ptr and lock are frozen.
- Fairness: after a completed packet from port g, every other valid port is served before g again.
- Simultaneous events:
  - All ports valid: grant rotates 0,1,2,3,0,...
  - The port at ptr is valid alone: it is re-granted, so back-to-back from the same port is allowed when no others are valid.
- NUM_PORTS=1: grant is always 0; out_sel=0; the FSM still tracks the lock.
- Reset mid-packet: lock is dropped, state=IDLE, ptr=NUM_PORTS-1. The word registered in the reset cycle is discarded (out_write=0 after reset). Upstream words are not consumed during reset.

Test Plan:
- Reset defaults: hold reset 3 cycles with all in_empty_n=1, out_full_n=1 -> in_read=0 throughout; out_write=0, out_sel=0, locked=0 the cycle after reset falls.
- Round robin: LOCK_ON_LAST=0, all 4 ports valid, 8 cycles, port i data = 0x100*i+k -> out_sel sequence 0,1,2,3,0,1,2,3; each word appears 1 cycle after its in_read.
- Packet lock: LOCK_ON_LAST=1, port 1 sends 3 words (last flag only on the 3rd), port 2 always valid, port 1 empty for 2 cycles mid-packet -> locked=1 throughout; port 2 not read until port 1's 3rd word; then out_sel=2.
- Backpressure: steady writes from port 0, drive out_full_n=0 for 5 cycles -> in_read=0 for those 5 cycles; out_write=0 from the following cycle; at most 1 write after out_full_n falls; no word lost or duplicated when out_full_n returns (scoreboard).
- Reset mid-packet: assert reset while locked on port 3 -> locked=0 next cycle; after release, port 0 wins when ports 0 and 3 are both valid.
- Random soak: 10k cycles, random in_empty_n, random out_full_n, random packet lengths 1..8 -> per-port order preserved, packets contiguous on the output, no port starved beyond NUM_PORTS-1 packets.
